// File: rtl/ucie_ctl_tx_buffer.sv
// ucie_ctl_tx_buffer: FDI-to-RDI transmit FIFO with first-word-fall-through output and sticky overrun flag
module ucie_ctl_tx_buffer #(
  parameter int NBYTES = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_buffer_en,
  input  logic [8*NBYTES-1:0]      i_fdi_lp_data,
  input  logic                     i_fdi_lp_valid,
  input  logic                     i_fdi_lp_irdy,
  output logic                     o_fdi_pl_trdy,
  output logic [8*NBYTES-1:0]      o_rdi_lp_data,
  output logic                     o_rdi_lp_valid,
  output logic                     o_rdi_lp_irdy,
  input  logic                     i_rdi_pl_trdy,
  output logic [$clog2(DEPTH):0]   o_fill_level,
  output logic                     o_overflow_detected
);
  localparam int W  = 8 * NBYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, req, push, pop;
  // Handshake decode and next-state; full blocks push even when a pop happens the same cycle
  always_comb begin
    full           = count_q == CW'(DEPTH);
    empty          = count_q == '0;
    req            = i_buffer_en && i_fdi_lp_valid && i_fdi_lp_irdy;
    push           = req && !full;
    o_fdi_pl_trdy  = i_buffer_en && !full;
    o_rdi_lp_valid = i_buffer_en && !empty;
    o_rdi_lp_irdy  = o_rdi_lp_valid;
    o_rdi_lp_data  = empty ? '0 : mem_q[rd_ptr_q];
    pop            = o_rdi_lp_valid && i_rdi_pl_trdy;
    wr_ptr_d       = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d       = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d        = count_q + CW'(push) - CW'(pop);
    ovf_d          = ovf_q || (req && full);
  end
  // Pointer, occupancy and overrun state with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end
  // Storage array; reset leaves contents alone since the pointers make them unreachable
  always_ff @(posedge i_clk) begin
    if (i_rst && push) mem_q[wr_ptr_q] <= i_fdi_lp_data;
  end
  assign o_fill_level        = count_q;
  assign o_overflow_detected = ovf_q;
endmodule
